// File: rtl/spi_cmd_regfile_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_pkg
// Shared definitions for the SPI command dispatcher: opcode values, frame
// field positions, response width and the dispatcher state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_cmd_pkg;

   // Frame layout: opcode in the low byte, payload in the upper 24 bits.
   localparam int OPCODE_LSB  = 0;
   localparam int PAYLOAD_LSB = 8;
   localparam int FRAME_W     = 32;
   localparam int OPCODE_W    = 8;
   localparam int PAYLOAD_W   = 24;
   localparam int RESP_W      = 24;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_INIT      = 8'h01;
   localparam logic [7:0] OP_WR_INV    = 8'h02;
   localparam logic [7:0] OP_RD_INV    = 8'h03;
   localparam logic [7:0] OP_WR_GPIO   = 8'h04;
   localparam logic [7:0] OP_RD_GPIO   = 8'h05;
   localparam logic [7:0] OP_WR_VEC    = 8'h06;
   localparam logic [7:0] OP_RD_VEC    = 8'h07;
   localparam logic [7:0] OP_SET_PTR   = 8'h08;
   localparam logic [7:0] OP_RD_STATUS = 8'h09;

   // GPIO field starts at payload bit 16 (frame bit 24).
   localparam int GPIO_PAYLOAD_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_RESP   = 2'd2,
      ST_STREAM = 2'd3
   } state_t;

endpackage

// File: rtl/spi_cmd_regfile_vecmem.sv
// -----------------------------------------------------------------------------
// spi_cmd_vecmem
// VEC_DEPTH x DATA_W register array for the command dispatcher.
// One synchronous write port, one asynchronous read port, synchronous clear.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (clears the array)
//   clr            synchronous clear of every entry
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port
// -----------------------------------------------------------------------------
module spi_cmd_vecmem
   import spi_cmd_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int VEC_DEPTH = 4,
   parameter int PTR_W     = $clog2(VEC_DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [VEC_DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < VEC_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < VEC_DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/spi_cmd_regfile.sv
// -----------------------------------------------------------------------------
// spi_cmd_regfile
// Command dispatcher between spi_slave and application logic. Each received
// 32-bit frame is split into opcode (bits 7:0) and payload (bits 31:8) and
// executed against an inversion register, a GPIO register, a vector memory
// with write pointer and a saturating error counter. Responses are pushed
// back through the spi_slave write port, honouring wr_buffer_free.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rd_data_available   spi_slave received-frame valid (level)
//   rd_data             received frame
//   rd_ack              one-cycle pulse: frame consumed
//   wr_buffer_free      spi_slave transmit buffer can take a word
//   wr_en, wr_data      one-cycle push of a response word (zero-extended)
//   gpio                GPIO/LED register, active-high
//   busy                high whenever the dispatcher is not idle
// -----------------------------------------------------------------------------
module spi_cmd_regfile
   import spi_cmd_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int VEC_DEPTH = 4,
   parameter int GPIO_W    = 3,
   parameter int PTR_W     = $clog2(VEC_DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_data_available,
   input  logic [31:0]       rd_data,
   output logic              rd_ack,
   input  logic              wr_buffer_free,
   output logic              wr_en,
   output logic [23:0]       wr_data,
   output logic [GPIO_W-1:0] gpio,
   output logic              busy
);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VEC_DEPTH - 1);

   state_t state, state_next;

   logic                 avail_d;
   logic                 pending;
   logic                 frame_edge;
   logic [FRAME_W-1:0]   frame_reg;
   logic [FRAME_W-1:0]   cmd_reg;
   logic [OPCODE_W-1:0]  opcode;
   logic [PAYLOAD_W-1:0] payload;

   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     idx;
   logic [DATA_W-1:0]    inv_reg;
   logic [7:0]           err_cnt;
   logic [RESP_W-1:0]    resp;
   logic [RESP_W-1:0]    resp_next;
   logic [DATA_W-1:0]    vec_rdata;

   logic load_resp;
   logic do_init;
   logic do_wr_inv;
   logic do_wr_gpio;
   logic do_wr_vec;
   logic do_set_ptr;
   logic err_exec;
   logic stream_start;
   logic stream_adv;
   logic overrun;
   logic err_inc;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign frame_edge = rd_data_available & ~avail_d;
   assign opcode     = cmd_reg[OPCODE_LSB +: OPCODE_W];
   assign payload    = cmd_reg[PAYLOAD_LSB +: PAYLOAD_W];
   assign busy       = (state != ST_IDLE);

   // A second edge while a frame is still waiting replaces it; the frame
   // being acknowledged this very cycle is not lost, so that is no overrun.
   assign overrun = frame_edge & pending & ~rd_ack;
   // Overrun and an EXEC error in the same cycle count once.
   assign err_inc = overrun | err_exec;

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      rd_ack       = 1'b0;
      wr_en        = 1'b0;
      wr_data      = '0;
      load_resp    = 1'b0;
      resp_next    = '0;
      do_init      = 1'b0;
      do_wr_inv    = 1'b0;
      do_wr_gpio   = 1'b0;
      do_wr_vec    = 1'b0;
      do_set_ptr   = 1'b0;
      err_exec     = 1'b0;
      stream_start = 1'b0;
      stream_adv   = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (pending) begin
               rd_ack     = 1'b1;
               state_next = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_next = ST_IDLE;
            case (opcode)
               OP_NOP: ;
               OP_INIT:    do_init    = 1'b1;
               OP_WR_INV:  do_wr_inv  = 1'b1;
               OP_WR_GPIO: do_wr_gpio = 1'b1;
               OP_WR_VEC:  do_wr_vec  = 1'b1;
               OP_RD_INV: begin
                  load_resp  = 1'b1;
                  resp_next  = RESP_W'(inv_reg);
                  state_next = ST_RESP;
               end
               OP_RD_GPIO: begin
                  load_resp  = 1'b1;
                  resp_next  = RESP_W'(gpio);
                  state_next = ST_RESP;
               end
               OP_RD_VEC: begin
                  stream_start = 1'b1;
                  state_next   = ST_STREAM;
               end
               OP_SET_PTR: begin
                  // Whole payload must name a valid entry; any upper bit set
                  // makes it out of range.
                  if (payload < PAYLOAD_W'(VEC_DEPTH)) do_set_ptr = 1'b1;
                  else                                 err_exec   = 1'b1;
               end
               OP_RD_STATUS: begin
                  load_resp  = 1'b1;
                  resp_next  = {err_cnt, 8'(ptr), 7'b0, pending};
                  state_next = ST_RESP;
               end
               default: err_exec = 1'b1;
            endcase
         end

         ST_RESP: begin
            if (wr_buffer_free) begin
               wr_en      = 1'b1;
               wr_data    = resp;
               state_next = ST_IDLE;
            end
         end

         ST_STREAM: begin
            if (wr_buffer_free) begin
               wr_en      = 1'b1;
               wr_data    = RESP_W'(vec_rdata);
               stream_adv = 1'b1;
               if (idx == LAST_IDX) state_next = ST_IDLE;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // ---------------------------------------------------------------------------
   // Control and architectural registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avail_d <= 1'b0;
         pending <= 1'b0;
         ptr     <= '0;
         idx     <= '0;
         inv_reg <= '0;
         gpio    <= '0;
         err_cnt <= '0;
      end else begin
         avail_d <= rd_data_available;

         if (frame_edge)  pending <= 1'b1;
         else if (rd_ack) pending <= 1'b0;

         if (do_init)        err_cnt <= '0;
         else if (err_inc)   err_cnt <= sat_inc8(err_cnt);

         if (do_init)         ptr <= '0;
         else if (do_set_ptr) ptr <= payload[PTR_W-1:0];
         else if (do_wr_vec)  ptr <= (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);

         if (stream_start)    idx <= '0;
         else if (stream_adv) idx <= idx + PTR_W'(1);

         if (do_init)        inv_reg <= '0;
         else if (do_wr_inv) inv_reg <= ~payload[DATA_W-1:0];

         if (do_init)         gpio <= '0;
         else if (do_wr_gpio) gpio <= payload[GPIO_PAYLOAD_LSB +: GPIO_W];
      end
   end

   // ---------------------------------------------------------------------------
   // Frame capture and response holding registers
   // ---------------------------------------------------------------------------
   // cmd_reg is a separate copy so a frame arriving during EXEC cannot alter
   // the command being decoded.
   always_ff @(posedge clk) begin
      if (frame_edge) frame_reg <= rd_data;
      if (rd_ack)     cmd_reg   <= frame_reg;
      if (load_resp)  resp      <= resp_next;
   end

   spi_cmd_vecmem #(
      .DATA_W    (DATA_W),
      .VEC_DEPTH (VEC_DEPTH),
      .PTR_W     (PTR_W)
   ) u_vecmem (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (do_init),
      .we      (do_wr_vec),
      .waddr   (ptr),
      .wdata   (payload[DATA_W-1:0]),
      .raddr   (idx),
      .rdata   (vec_rdata)
   );

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
Parametrised command dispatcher between spi_slave and application logic. It generalises the fixed 4-entry LED/vector command decoder with the following:
- configurable vector depth, data width and GPIO count;
- an explicit pointer-set command;
- a status readback with an error counter;
- a handshake-correct response path that waits on wr_buffer_free.

Each 32-bit SPI frame is decoded as opcode = frame[7:0] and payload = frame[31:8]. Responses go back through spi_slave's write port.

Parameters:
DATA_W, 24, payload/response width; fixed by spi_slave framing, must be ≤24
VEC_DEPTH, 4, number of vector entries, legal range 2..256
GPIO_W, 3, width of the GPIO/LED output register, must be ≤DATA_W
PTR_W, $clog2(VEC_DEPTH), derived pointer width; not to be overridden

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rd_data_available  in  1  spi_slave: received frame valid (level)
rd_data  in  32  spi_slave: received frame
rd_ack  out  1  one-cycle pulse, frame consumed
wr_buffer_free  in  1  spi_slave: transmit buffer can accept a word
wr_en  out  1  one-cycle pulse, push wr_data
wr_data  out  24  response word, zero-extended from DATA_W
gpio  out  GPIO_W  GPIO/LED register, active-high
busy  out  1  high whenever state != IDLE

Behaviour:
Reset (asynchronous, reset_n=0):
- state=IDLE; all outputs 0.
- vector[] = 0, ptr = 0, inv_reg = 0, err_cnt = 0, pending = 0, avail_d = 0.

Frame detection:
- avail_d <= rd_data_available.
- A rising edge (available=1 and avail_d=0) sets pending and latches rd_data into frame_reg.
- An edge arriving in a non-IDLE state is held in pending. A second edge before service overwrites frame_reg and increments err_cnt (overrun).

States: IDLE, EXEC, RESP, STREAM.
- IDLE: if pending, then rd_ack=1, pending cleared, go EXEC. Latency is edge cycle +1 for rd_ack.
- EXEC: one cycle; decode opcode:
  - 0x00 NOP: go IDLE.
  - 0x01 INIT: clear vector[], ptr, inv_reg, gpio, err_cnt; go IDLE.
  - 0x02 WR_INV: inv_reg <= ~payload[DATA_W-1:0]; go IDLE.
  - 0x03 RD_INV: resp <= inv_reg; go RESP.
  - 0x04 WR_GPIO: gpio <= payload[16+GPIO_W-1:16], i.e. frame bits [24+GPIO_W-1:24]; go IDLE.
  - 0x05 RD_GPIO: resp <= zero-extended gpio; go RESP.
  - 0x06 WR_VEC: vector[ptr] <= payload; ptr <= (ptr==VEC_DEPTH-1) ? 0 : ptr+1; go IDLE.
  - 0x07 RD_VEC: idx <= 0; go STREAM.
  - 0x08 SET_PTR:
    - if payload[PTR_W-1:0] < VEC_DEPTH and the upper payload bits are 0, then ptr <= payload;
    - else ptr is unchanged and err_cnt increments.
    - go IDLE.
  - 0x09 RD_STATUS: resp <= {err_cnt[7:0], 8'(ptr), 7'b0, pending}; go RESP.
  - other: err_cnt increments; go IDLE.
- RESP: when wr_buffer_free=1, then wr_en=1 and wr_data=resp; go IDLE. Minimum response latency is EXEC+1. It waits indefinitely while the buffer is full.
- STREAM: each cycle with wr_buffer_free=1, then wr_en=1, wr_data=vector[idx], idx+1.
  - After VEC_DEPTH words, go IDLE.
  - ptr is not modified by the stream.
  - wr_en is never asserted when wr_buffer_free=0.

Counter and timing rules:
- err_cnt is 8 bits and saturates at 255.
- A simultaneous overrun plus unknown opcode increments err_cnt by 1 only.
- wr_en and rd_ack are never high in the same cycle. Back-to-back frames are serviced in arrival order; only the newest pending frame is kept.
- Reset mid-STREAM or mid-RESP aborts immediately; no further wr_en.

Decomposition:
- Shared package spi_cmd_pkg:
  - opcode localparams OP_NOP..OP_RD_STATUS;
  - state encoding;
  - field constants OPCODE_LSB=0, PAYLOAD_LSB=8.
- Optional sub-module spi_cmd_vecmem: VEC_DEPTH×DATA_W register array, one write port, one async read port, synchronous clear. The FSM stays in the top.

Test Plan:
- Reset, then frame 0x00ABCD02 (WR_INV), then frame 0x03 (RD_INV) -> wr_data=0xFF5432, exactly one wr_en; rd_ack one cycle after each edge.
- WR_GPIO with frame 0x05000004 -> gpio=3'b101; RD_GPIO -> wr_data=0x000005.
- Four WR_VEC frames with payloads 0x000011/22/33/44, then RD_VEC with wr_buffer_free toggling 1,0,1,1,0,1 -> exactly 4 wr_en pulses, data 11,22,33,44 in order, none while free=0.
- SET_PTR 2, WR_VEC 0x0000AA, RD_VEC -> third word 0x0000AA. SET_PTR 4 (VEC_DEPTH=4) -> ptr unchanged. RD_STATUS -> err_cnt field = 1.
- Opcode 0x7F 300 times, then RD_STATUS -> err_cnt=0xFF (saturated). INIT, then RD_STATUS -> 0x000000.
- Assert reset_n=0 during STREAM after 2 words -> wr_en drops immediately, busy=0, gpio=0. After release, RD_VEC streams four zeros.
